// File: rtl/alu_arb_pkg.sv
// Shared constants and the ALU stage register layout for the ALU-sharing arbiter.
package alu_arb_pkg;

  // Default operand/result and control widths of the core ALU.
  localparam int ARB_DATA_W = 32;
  localparam int ARB_CTRL_W = 5;

  // Upper bounds the stage register is sized for; a configuration must fit inside them.
  localparam int ARB_MAX_REQ    = 8;
  localparam int ARB_OWNER_W    = 3;
  localparam int ARB_DATA_W_MAX = 64;
  localparam int ARB_CTRL_W_MAX = 16;

  // ALU input stage: the granted operation plus the requester that owns its result.
  // Narrower configurations zero-extend into the fields.
  typedef struct packed {
    logic                      valid;
    logic [ARB_OWNER_W-1:0]    owner;
    logic [ARB_DATA_W_MAX-1:0] a;
    logic [ARB_DATA_W_MAX-1:0] b;
    logic [ARB_CTRL_W_MAX-1:0] ctrl;
  } arb_stage_t;

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin one-hot selector: the first eligible requester after last_grant wins.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_any
);

  // Walk the requesters starting one past the previous winner, wrapping at N.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(last_grant) + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (!grant_any && eligible[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
        grant_any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ requesters,
// with a registered ALU input stage and a held response slot per requester.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = ARB_DATA_W,
  parameter int CTRL_W = ARB_CTRL_W
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_a,
  input  logic [N_REQ*DATA_W-1:0]   req_b,
  input  logic [N_REQ*CTRL_W-1:0]   req_ctrl,
  output logic [N_REQ-1:0]          rsp_valid,
  input  logic [N_REQ-1:0]          rsp_ready,
  output logic [N_REQ*DATA_W-1:0]   rsp_result,
  output logic [N_REQ-1:0]          rsp_zero,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [CTRL_W-1:0]         alu_ctrl,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic                      alu_zero
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_stage_t        op_q;
  logic [IDX_W-1:0]  last_grant_q;
  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [CTRL_W-1:0] sel_ctrl;
  logic              unused_stage_bits;

  // A requester may be granted only with nothing of its own in the ALU stage and a slot
  // that is empty or being drained this cycle; nothing is granted while reset is held.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = RESET_N && req_valid[i]
                    && !(op_q.valid && (op_q.owner == ARB_OWNER_W'(i)))
                    && (!rsp_valid[i] || rsp_ready[i]);
    end
  end

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  assign req_ready = grant;

  assign sel_a    = req_a[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_b    = req_b[int'(grant_idx)*DATA_W +: DATA_W];
  assign sel_ctrl = req_ctrl[int'(grant_idx)*CTRL_W +: CTRL_W];

  // Round-robin pointer advances only when a handshake happens; reset points at the
  // last requester so requester 0 is searched first.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      last_grant_q <= IDX_W'(N_REQ - 1);
    end else if (grant_any) begin
      last_grant_q <= grant_idx;
    end
  end

  // ALU input stage: load the winner on a handshake; otherwise only the valid bit drops,
  // so the operands stay put and the ALU inputs do not toggle while idle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q <= '0;
    end else if (grant_any) begin
      op_q.valid <= 1'b1;
      op_q.owner <= ARB_OWNER_W'(grant_idx);
      op_q.a     <= ARB_DATA_W_MAX'(sel_a);
      op_q.b     <= ARB_DATA_W_MAX'(sel_b);
      op_q.ctrl  <= ARB_CTRL_W_MAX'(sel_ctrl);
    end else begin
      op_q.valid <= 1'b0;
    end
  end

  assign alu_a    = op_q.a[DATA_W-1:0];
  assign alu_b    = op_q.b[DATA_W-1:0];
  assign alu_ctrl = op_q.ctrl[CTRL_W-1:0];

  // Zero-extension bits above the configured widths carry no information.
  assign unused_stage_bits = ^{op_q.a, op_q.b, op_q.ctrl};

  for (genvar g = 0; g < N_REQ; g++) begin : g_slot
    logic              capture;
    logic              valid_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;

    assign capture = op_q.valid && (op_q.owner == ARB_OWNER_W'(g));

    // Response slot: a capture wins over a same-edge acknowledge so a fresh result is
    // never dropped; the held value only changes on a capture.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        valid_q  <= 1'b0;
        result_q <= '0;
        zero_q   <= 1'b0;
      end else if (capture) begin
        valid_q  <= 1'b1;
        result_q <= alu_result;
        zero_q   <= alu_zero;
      end else if (rsp_ready[g]) begin
        valid_q  <= 1'b0;
      end
    end

    assign rsp_valid[g]                    = valid_q;
    assign rsp_result[g*DATA_W +: DATA_W]  = result_q;
    assign rsp_zero[g]                     = zero_q;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: grants and responses are predicted from the
// arbitration rules with per-requester queues and checked every cycle at the falling edge.
module tb_alu_share_arbiter;

  localparam int N_REQ  = 2;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 5;

  localparam logic [CTRL_W-1:0] OP_ADD = 5'd0;
  localparam logic [CTRL_W-1:0] OP_SUB = 5'd1;
  localparam logic [CTRL_W-1:0] OP_AND = 5'd2;
  localparam logic [CTRL_W-1:0] OP_OR  = 5'd3;
  localparam logic [CTRL_W-1:0] OP_XOR = 5'd4;

  logic                    CLK;
  logic                    RESET_N;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_a;
  logic [N_REQ*DATA_W-1:0] req_b;
  logic [N_REQ*CTRL_W-1:0] req_ctrl;
  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [N_REQ*DATA_W-1:0] rsp_result;
  logic [N_REQ-1:0]        rsp_zero;
  logic [DATA_W-1:0]       alu_a;
  logic [DATA_W-1:0]       alu_b;
  logic [CTRL_W-1:0]       alu_ctrl;
  logic [DATA_W-1:0]       alu_result;
  logic                    alu_zero;

  typedef struct {
    logic [DATA_W-1:0] result;
    logic              zero;
    int                cyc;
  } sb_entry_t;

  sb_entry_t         sb_q [N_REQ][$];
  int                tests = 0;
  int                fails = 0;
  int                cyc   = 0;
  int                gcount [N_REQ];
  int                mdl_last;
  logic [DATA_W-1:0] mdl_alu_a;
  logic [DATA_W-1:0] mdl_alu_b;
  logic [CTRL_W-1:0] mdl_alu_ctrl;
  logic [N_REQ-1:0]  m_mat, m_stage, m_elig, m_grant;
  logic              m_found;

  alu_share_arbiter #(
    .N_REQ  (N_REQ),
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  function automatic logic [DATA_W-1:0] alu_fn(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b,
                                               input logic [CTRL_W-1:0] c);
    case (c)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return b;
    endcase
  endfunction

  // Stand-in for the core's combinational ALU.
  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == '0);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor and reference model: predicts the grant, the ALU drive and each slot's
  // contents from the request history, then retires and records handshakes.
  always @(negedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < N_REQ; i++) sb_q[i].delete();
      mdl_last     = N_REQ - 1;
      mdl_alu_a    = '0;
      mdl_alu_b    = '0;
      mdl_alu_ctrl = '0;
      chk("reset_req_ready",  64'(req_ready),  64'(0));
      chk("reset_rsp_valid",  64'(rsp_valid),  64'(0));
      chk("reset_rsp_result", 64'(rsp_result), 64'(0));
      chk("reset_rsp_zero",   64'(rsp_zero),   64'(0));
      chk("reset_alu_a",      64'(alu_a),      64'(0));
      chk("reset_alu_b",      64'(alu_b),      64'(0));
      chk("reset_alu_ctrl",   64'(alu_ctrl),   64'(0));
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        m_mat[i]   = (sb_q[i].size() > 0) && (sb_q[i][0].cyc <= cyc - 2);
        m_stage[i] = (sb_q[i].size() > 0) && (sb_q[i][$].cyc == cyc - 1);
        m_elig[i]  = req_valid[i] && !m_stage[i] && (!m_mat[i] || rsp_ready[i]);
      end
      m_grant = '0;
      m_found = 1'b0;
      for (int off = 1; off <= N_REQ; off++) begin
        int j;
        j = (mdl_last + off) % N_REQ;
        if (!m_found && m_elig[j]) begin
          m_grant[j] = 1'b1;
          m_found    = 1'b1;
        end
      end
      chk("req_ready", 64'(req_ready), 64'(m_grant));
      chk("alu_a",     64'(alu_a),     64'(mdl_alu_a));
      chk("alu_b",     64'(alu_b),     64'(mdl_alu_b));
      chk("alu_ctrl",  64'(alu_ctrl),  64'(mdl_alu_ctrl));
      for (int i = 0; i < N_REQ; i++) begin
        chk($sformatf("rsp_valid[%0d]", i), 64'(rsp_valid[i]), 64'(m_mat[i]));
        if (m_mat[i]) begin
          chk($sformatf("rsp_result[%0d]", i), 64'(rsp_result[i*DATA_W +: DATA_W]),
              64'(sb_q[i][0].result));
          chk($sformatf("rsp_zero[%0d]", i), 64'(rsp_zero[i]), 64'(sb_q[i][0].zero));
          if (rsp_ready[i]) void'(sb_q[i].pop_front());
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (m_grant[i]) begin
          sb_entry_t e;
          e.result = alu_fn(req_a[i*DATA_W +: DATA_W], req_b[i*DATA_W +: DATA_W],
                            req_ctrl[i*CTRL_W +: CTRL_W]);
          e.zero   = (e.result == '0);
          e.cyc    = cyc;
          sb_q[i].push_back(e);
          mdl_last     = i;
          mdl_alu_a    = req_a[i*DATA_W +: DATA_W];
          mdl_alu_b    = req_b[i*DATA_W +: DATA_W];
          mdl_alu_ctrl = req_ctrl[i*CTRL_W +: CTRL_W];
          gcount[i]++;
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                         input logic [CTRL_W-1:0] c);
    req_a[i*DATA_W +: DATA_W]    = a;
    req_b[i*DATA_W +: DATA_W]    = b;
    req_ctrl[i*CTRL_W +: CTRL_W] = c;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N_REQ; i++) begin
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : DATA_W'($urandom);
      set_req(i, a, b, CTRL_W'($urandom_range(0, 5)));
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_rsp(input int i, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (rsp_valid[i]) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  int                g0, g1;
  bit                seen;
  logic [DATA_W-1:0] held_a;

  initial begin
    RESET_N   = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    rsp_ready = '0;
    for (int i = 0; i < N_REQ; i++) gcount[i] = 0;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;

    // single op: 5 + 7
    set_req(0, 32'd5, 32'd7, OP_ADD);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    next_cycle();
    req_valid = 2'b00;
    wait_rsp(0, seen);
    chk("single_add_seen",   64'(seen), 64'(1));
    chk("single_add_result", 64'(rsp_result[DATA_W-1:0]), 64'(12));
    chk("single_add_zero",   64'(rsp_zero[0]), 64'(0));

    // single op: 5 + (-5) gives zero
    next_cycle();
    set_req(0, 32'd5, 32'hFFFF_FFFB, OP_ADD);
    req_valid = 2'b01;
    next_cycle();
    req_valid = 2'b00;
    wait_rsp(0, seen);
    chk("zero_add_seen",   64'(seen), 64'(1));
    chk("zero_add_result", 64'(rsp_result[DATA_W-1:0]), 64'(0));
    chk("zero_add_zero",   64'(rsp_zero[0]), 64'(1));
    next_cycle();

    // contention: both requesters always valid and draining
    g0 = gcount[0];
    g1 = gcount[1];
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    repeat (12) begin
      rand_ops();
      next_cycle();
    end
    chk("contention_grants_r0", 64'(gcount[0] - g0), 64'(6));
    chk("contention_grants_r1", 64'(gcount[1] - g1), 64'(6));

    // backpressure on requester 1
    g0 = gcount[0];
    g1 = gcount[1];
    rsp_ready = 2'b01;
    repeat (20) begin
      rand_ops();
      next_cycle();
    end
    chk("bp_r0_keeps_going", 64'((gcount[0] - g0) >= 9), 64'(1));
    chk("bp_r1_blocked",     64'((gcount[1] - g1) <= 1), 64'(1));
    @(negedge CLK);
    held_a = rsp_result[DATA_W +: DATA_W];
    repeat (5) begin
      next_cycle();
      rand_ops();
    end
    @(negedge CLK);
    chk("bp_r1_held_valid",  64'(rsp_valid[1]), 64'(1));
    chk("bp_r1_held_stable", 64'(rsp_result[DATA_W +: DATA_W]), 64'(held_a));
    next_cycle();
    g1 = gcount[1];
    rsp_ready = 2'b11;
    repeat (10) begin
      rand_ops();
      next_cycle();
    end
    chk("bp_r1_resumes", 64'((gcount[1] - g1) >= 3), 64'(1));

    // single requester re-granted as its previous result drains
    g0 = gcount[0];
    req_valid = 2'b01;
    repeat (12) begin
      rand_ops();
      next_cycle();
    end
    chk("drain_regrant_r0", 64'((gcount[0] - g0) >= 5), 64'(1));

    // random soak with a reset pulse in the middle
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_valid[i] = ($urandom_range(0, 3) != 0);
        rsp_ready[i] = ($urandom_range(0, 9) < 7);
      end
      rand_ops();
      if (c == 200) RESET_N = 1'b0;
      if (c == 202) RESET_N = 1'b1;
      next_cycle();
    end

    // drain everything still outstanding
    req_valid = '0;
    rsp_ready = 2'b11;
    repeat (5) next_cycle();
    @(negedge CLK);
    chk("final_drain_r0", 64'(sb_q[0].size()), 64'(0));
    chk("final_drain_r1", 64'(sb_q[1].size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
